// File: rtl/uart_tx.sv
// uart_tx: bus-mapped UART transmitter with a byte FIFO.
// Frame: start(0), 8 data bits LSB first, even parity, stop(1).
`default_nettype none

module uart_tx #(
    parameter int          clk_tx     = 50000,
    parameter int          Baudrate   = 10000,
    parameter int          BitClks    = clk_tx / Baudrate,
    parameter logic [31:0] address_tx = 32'h0040_0104,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        we,
    input  logic [7:0]  data_in,
    output logic        data_tx,
    output logic        busy,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BitClks);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [BW-1:0] bcnt;
    logic [2:0]    idx;
    logic [7:0]    sh;
    logic [7:0]    sh_nxt;
    logic          par;
    logic          par_nxt;
    logic          tx_nxt;
    logic          bit_end;
    logic          pop;
    logic          push;
    logic          wr_hit;
    logic [7:0]    head;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    assign wr_hit  = we && (address == address_tx);
    assign push    = wr_hit && !full;
    assign head    = mem[rptr];
    assign bit_end = (bcnt == BW'(BitClks - 1));

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign busy  = (state != S_IDLE);

    // FIFO storage carries no reset; only pointers and count are flushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_hit && full;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (idx == 3'd7)) state_nxt = S_PARITY;
            end
            S_PARITY: begin
                if (bit_end) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The line value is computed from next-state data so data_tx can be a flop.
    always_comb begin
        sh_nxt  = sh;
        par_nxt = par;
        if (pop) begin
            sh_nxt  = head;
            par_nxt = ^head;
        end else if ((state == S_DATA) && bit_end) begin
            sh_nxt = {1'b0, sh[7:1]};
        end
        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = sh_nxt[0];
            S_PARITY: tx_nxt = par_nxt;
            default:  tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt    <= '0;
            idx     <= '0;
            sh      <= '0;
            par     <= 1'b0;
            data_tx <= 1'b1;
        end else begin
            sh      <= sh_nxt;
            par     <= par_nxt;
            data_tx <= tx_nxt;
            if ((state == S_IDLE) || bit_end) begin
                bcnt <= '0;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
            if (state != S_DATA) begin
                idx <= '0;
            end else if (bit_end) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Memory-mapped UART transmitter, the upstream stage of the UART receiver. It accepts bytes from the system bus at address `address_tx`, buffers them in a small FIFO, and serialises each one onto `data_tx`. The frame format matches the receiver exactly: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).

## Interface
Parameters:
- `clk_tx`, 50000: input clock frequency in Hz.
- `Baudrate`, 10000: serial bit rate.
- `BitClks`, `clk_tx/Baudrate` (derived, 5): clocks per bit. Must be an integer ≥ 2.
- `address_tx`, 'h400104: bus address of the transmit data register.
- `FIFO_DEPTH`, 4: byte FIFO depth, a power of two ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  32  bus address.
- `we`  in  1  bus write strobe.
- `data_in`  in  8  bus write data.
- `data_tx`  out  1  serial line, idles high, registered.
- `busy`  out  1  a frame is in progress.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `overflow`  out  1  one-cycle pulse when a write is dropped.

## Operation
- **Write acceptance**
  - A write is a cycle with `we`=1 and `address`=`address_tx`.
  - If `full`=0, `data_in` is pushed into the FIFO.
  - If `full`=1, the byte is dropped and `overflow` pulses on the next cycle.
  - `full` is the value registered before the edge. A pop in the same cycle does not rescue a write made while full.
  - Writes to any other address are ignored.
- **FIFO**
  - Circular buffer with a count register of width log2(FIFO_DEPTH)+1.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A push and a pop in the same cycle leave the count unchanged.
- **FSM states**: IDLE, START, DATA, PARITY, STOP.
  - A bit-period counter `bcnt` runs 0..BitClks-1. Each state lasts BitClks cycles.
  - IDLE: `data_tx`=1. If FIFO is not empty, pop the head into shift register `sh`, latch parity = ^byte, go to START.
  - START: `data_tx`=0. Then go to DATA with bit index 0.
  - DATA: `data_tx`=`sh[0]`. At the end of each bit, shift `sh` right and increment the index. After index 7 completes, go to PARITY.
  - PARITY: `data_tx`=parity, so the total count of ones in data+parity is even. Then go to STOP.
  - STOP: `data_tx`=1. At the end:
    - if FIFO is not empty, pop and go directly to START, with no idle gap;
    - otherwise go to IDLE.
- `busy`=1 in START, DATA, PARITY and STOP.
- `empty` and `full` decode the count register.

## Timing
- **Reset values**: `data_tx`=1, `busy`=0, `full`=0, `empty`=1, `overflow`=0.
- **Reset effects**: FSM goes to IDLE, FIFO is flushed, `bcnt`=0.
- **Reset mid-frame**: `data_tx` returns to 1 immediately (asynchronously). The partial frame and any queued bytes are lost. After reset release, no output occurs until a new write.
- **Write latency**:
  - Write accepted at edge N: `empty` drops after N.
  - Pop and START entry happen at edge N+1, so `data_tx` goes low after N+1.
  - `empty` returns to 1 after N+1 if nothing else is queued.
- **Frame length**: 11×BitClks cycles (55 at defaults). Back-to-back frames are contiguous.
- `busy` falls after the final STOP cycle if the FIFO is empty.
- `overflow` is high for exactly one cycle per dropped write.

## Test plan
- **Single byte**: write 0xA5 to 'h400104.
  - `data_tx` from N+1 carries 0, then 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - Each bit holds 5 cycles; `busy` is high for 55 cycles, then IDLE.
- **Loopback**: connect `data_tx` to the receiver and write 0x3C, then 0x01.
  - The receiver shows `data_out`=0x3C with `we` pulse, then 0x01 with `we` pulse.
  - The parity check passes.
- **Overflow**: write 6 consecutive cycles while idle (0x10..0x15).
  - `full`=1 after the 5th write.
  - The 6th write is dropped with one `overflow` pulse.
  - 0x10..0x14 are transmitted as five contiguous frames (275 cycles); then `empty`=1 and `busy`=0.
- **Address decode**: write 0x55 to 'h400100.
  - No FIFO change, `empty` stays 1, `data_tx` stays 1.
- **Reset mid-frame**: queue 0xFF and 0x00, then assert reset during DATA bit 3.
  - `data_tx`=1 immediately and all outputs return to reset values.
  - After release, the line stays idle for ≥100 cycles.
- **Back-to-back**: write 0x00, then 0xFF one cycle later.
  - The two frames are adjacent: the STOP of frame 1 is followed immediately by START of frame 2.
  - Frame 2 has parity 0.
